// File: rtl/uart_tx_framed.sv
// uart_tx_framed: FIFO-buffered UART transmitter, configurable data/stop bits; define UART_TX_PARITY_EN for a per-word parity bit
module uart_tx_framed #(
  parameter int CLOCK_FREQUENCY = 12_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  input  logic [DATA_BITS-1:0]          i_tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          i_parity_odd,
`endif
  output logic                          o_uart_tx,
  output logic                          o_uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam int FW = DATA_BITS + 1;
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam int FW = DATA_BITS;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, next;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] wdata, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [BW-1:0] baud;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic push, pop, baud_end, empty, tx_d;
`ifdef UART_TX_PARITY_EN
  logic par;
  assign wdata = {i_parity_odd, i_tx_data};
`else
  assign wdata = i_tx_data;
`endif
  assign head         = mem[rd_ptr];
  assign empty        = level == '0;
  assign o_tx_ready   = level != LW'(FIFO_DEPTH);
  assign o_fifo_level = level;
  assign o_uart_busy  = state != IDLE || !empty;
  assign push         = i_tx_valid && o_tx_ready;
  assign pop          = (state == IDLE || state == STOP) && next == START;
  assign baud_end     = baud == BW'(CPB - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = empty ? IDLE : START;
      START:   next = baud_end ? DATA : START;
      DATA:    next = (baud_end && bit_cnt == 4'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  next = baud_end ? STOP : PARITY;
`endif
      STOP:    next = (baud_end && bit_cnt == 4'(STOP_BITS - 1)) ? (empty ? IDLE : START) : STOP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    tx_d = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state == PARITY) tx_d = par;
`endif
  end
  // bit_cnt counts data bits in DATA and stop bits in STOP; both counters restart on every state change
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      baud      <= '0;
      bit_cnt   <= '0;
      o_uart_tx <= 1'b1;
    end else begin
      baud      <= (state == IDLE || baud_end || state != next) ? '0 : baud + BW'(1);
      bit_cnt   <= (state != next) ? '0 : bit_cnt + 4'(baud_end && (state == DATA || state == STOP));
      o_uart_tx <= tx_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (pop) shreg <= head[DATA_BITS-1:0];
    else if (state == DATA && baud_end) shreg <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
    if (pop) par <= ^head[DATA_BITS-1:0] ^ head[DATA_BITS];
`endif
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: scoreboard bench; a monitor per instance rebuilds each serial frame and checks it against queued expectations
module tb_uart_tx_framed;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FR  = (1 + 8 + P + 1) * 10;
  localparam int FRB = (1 + 5 + P + 2) * 10;
  typedef struct {logic [15:0] bits; int n;} frame_t;
  logic clk = 0, rst = 1;
  logic valid_a = 0, ready_a, line_a, busy_a;
  logic [7:0] data_a = 0;
  logic [2:0] lvl_a;
  logic valid_b = 0, ready_b, line_b, busy_b;
  logic [4:0] data_b = 0;
  logic [2:0] lvl_b;
`ifdef UART_TX_PARITY_EN
  logic odd_a = 0, odd_b = 0;
`endif
  int cyc = 0, checks = 0, errors = 0;
  bit hold_mon = 1;
  frame_t exp_a[$], exp_b[$];
  int start_a[$], start_b[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_framed #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(valid_a), .o_tx_ready(ready_a), .i_tx_data(data_a),
`ifdef UART_TX_PARITY_EN
    .i_parity_odd(odd_a),
`endif
    .o_uart_tx(line_a), .o_uart_busy(busy_a), .o_fifo_level(lvl_a));
  uart_tx_framed #(.CLOCK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(valid_b), .o_tx_ready(ready_b), .i_tx_data(data_b),
`ifdef UART_TX_PARITY_EN
    .i_parity_odd(odd_b),
`endif
    .o_uart_tx(line_b), .o_uart_busy(busy_b), .o_fifo_level(lvl_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic frame_t mk(input logic [8:0] d, input int nd, input logic pb, input int ns);
    frame_t f;
    int k;
    f.bits = '0;
    k = 1;
    for (int i = 0; i < nd; i++) begin f.bits[k] = d[i]; k++; end
    if (P == 1) begin f.bits[k] = pb; k++; end
    for (int i = 0; i < ns; i++) begin f.bits[k] = 1'b1; k++; end
    f.n = k;
    return f;
  endfunction
  // Each frame is checked cycle by cycle; every bit must hold its value for exactly 10 clocks
  task automatic monitor(input int sel);
    frame_t f;
    logic [15:0] got;
    logic ln;
    int glitch;
    bit abort;
    forever begin
      @(negedge clk);
      ln = sel ? line_b : line_a;
      if (ln === 1'b0 && !hold_mon) begin
        if (sel == 1) start_b.push_back(cyc); else start_a.push_back(cyc);
        if ((sel == 1 ? exp_b.size() : exp_a.size()) == 0) begin
          chk(sel ? "unexpected_frame_b" : "unexpected_frame_a", 32'(1), 32'(0));
          f.bits = '0;
          f.n = 1;
        end else f = (sel == 1) ? exp_b.pop_front() : exp_a.pop_front();
        got = '0;
        glitch = 0;
        abort = 0;
        for (int n = 0; n < f.n * 10; n++) begin
          if (n > 0) @(negedge clk);
          if (hold_mon) begin abort = 1; break; end
          ln = sel ? line_b : line_a;
          if (ln !== f.bits[n / 10]) glitch++;
          if (n % 10 == 5) got[n / 10] = ln;
        end
        if (!abort) begin
          chk(sel ? "frame_b" : "frame_a", 32'(got), 32'(f.bits));
          chk(sel ? "bit_timing_b" : "bit_timing_a", 32'(glitch), 32'(0));
        end
      end
    end
  endtask
  task automatic send_a(input logic [7:0] d, input logic odd, input logic pb, output int acc);
    bit ok;
    logic rdy;
    ok = 0;
    valid_a = 1;
    data_a = d;
`ifdef UART_TX_PARITY_EN
    odd_a = odd;
`else
    if (odd) ok = 0;
`endif
    for (int t = 0; t < 400; t++) begin
      rdy = ready_a;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    acc = cyc;
    if (ok) exp_a.push_back(mk({1'b0, d}, 8, pb, 1));
    else chk("accept_timeout_a", 32'(0), 32'(1));
  endtask
  task automatic wait_idle_a();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("idle_timeout_a", 32'(busy_a), 32'(0));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int acc, a0, a1, lows;
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_line", 32'(line_a), 32'(1));
      chk("rst_ready", 32'(ready_a), 32'(1));
      chk("rst_level", 32'(lvl_a), 32'(0));
      chk("rst_busy", 32'(busy_a), 32'(0));
    end
    hold_mon = 0;
    start_a.delete();
    send_a(8'h5a, 1'b0, 1'b0, acc);
    valid_a = 0;
    chk("level_after_accept", 32'(lvl_a), 32'(1));
    chk("busy_after_accept", 32'(busy_a), 32'(1));
    for (int t = 0; t < 10 && start_a.size() == 0; t++) @(negedge clk);
    chk("start_latency", (start_a.size() > 0) ? 32'(start_a[0] - acc) : 32'hffff_ffff, 32'(2));
    while (cyc < acc + FR) @(negedge clk);
    chk("busy_before_end", 32'(busy_a), 32'(1));
    @(negedge clk);
    chk("busy_falls", 32'(busy_a), 32'(0));
    chk("level_after_frame", 32'(lvl_a), 32'(0));
`ifdef UART_TX_PARITY_EN
    start_a.delete();
    send_a(8'h07, 1'b0, 1'b1, a0);
    send_a(8'h07, 1'b1, 1'b0, a1);
    valid_a = 0;
    wait_idle_a();
    chk("parity_frame_len", (start_a.size() == 2) ? 32'(start_a[1] - start_a[0]) : 32'hffff_ffff, 32'(FR));
`endif
    wait_idle_a();
    start_a.delete();
    for (int i = 0; i < 6; i++) begin
      send_a(8'(i), 1'b0, ^8'(i), acc);
      if (i == 4) begin
        chk("burst_level_full", 32'(lvl_a), 32'(4));
        chk("burst_ready_low", 32'(ready_a), 32'(0));
      end
    end
    valid_a = 0;
    wait_idle_a();
    chk("burst_frames", 32'(start_a.size()), 32'(6));
    for (int i = 1; i < 6; i++)
      chk("burst_gap", (start_a.size() > i) ? 32'(start_a[i] - start_a[i - 1]) : 32'hffff_ffff, 32'(FR));
    chk("ready_b_idle", 32'(ready_b), 32'(1));
    start_b.delete();
    valid_b = 1;
    data_b = 5'h1f;
    @(posedge clk);
    @(negedge clk);
    valid_b = 0;
    acc = cyc;
    exp_b.push_back(mk(9'h1f, 5, 1'b1, 2));
    for (int t = 0; t < 10 && start_b.size() == 0; t++) @(negedge clk);
    chk("start_latency_b", (start_b.size() > 0) ? 32'(start_b[0] - acc) : 32'hffff_ffff, 32'(2));
    while (cyc < acc + FRB) @(negedge clk);
    chk("busy_b_before_end", 32'(busy_b), 32'(1));
    @(negedge clk);
    chk("busy_b_falls", 32'(busy_b), 32'(0));
    send_a(8'ha5, 1'b0, 1'b0, a0);
    send_a(8'h3c, 1'b0, 1'b0, a1);
    send_a(8'h81, 1'b0, 1'b0, acc);
    valid_a = 0;
    chk("queued_level", 32'(lvl_a), 32'(2));
    while (cyc < a0 + 40) @(negedge clk);
    hold_mon = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_line", 32'(line_a), 32'(1));
    chk("midrst_level", 32'(lvl_a), 32'(0));
    chk("midrst_busy", 32'(busy_a), 32'(0));
    chk("midrst_ready", 32'(ready_a), 32'(1));
    rst = 0;
    exp_a.delete();
    start_a.delete();
    @(negedge clk);
    hold_mon = 0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (line_a !== 1'b1) lows++;
    end
    chk("no_frames_after_rst", 32'(lows), 32'(0));
    chk("no_starts_after_rst", 32'(start_a.size()), 32'(0));
    chk("busy_after_rst", 32'(busy_a), 32'(0));
    chk("exp_a_drained", 32'(exp_a.size()), 32'(0));
    chk("exp_b_drained", 32'(exp_b.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised UART transmitter that extends the fixed 8N3 transmitter. Data width and stop-bit count are configurable, and transmit words are buffered in an internal FIFO behind a valid/ready handshake. Parity is optional and selected at compile time. The block sits between on-chip producers (debug/log streams) and the board UART TX pin, and sends back-to-back frames without idle gaps.

## Interface
Parameters:
- CLOCK_FREQUENCY, 12_000_000, i_clk frequency in Hz
- BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (floor), must be >= 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits per frame, legal 1..2
- FIFO_DEPTH, 4, words buffered, power of two, >= 2

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; one clock; reset is synchronous and active-high
- i_tx_valid  input  1  producer has a word
- o_tx_ready  output  1  FIFO not full; a word is accepted on any edge with i_tx_valid && o_tx_ready
- i_tx_data  input  DATA_BITS  word to send
- i_parity_odd  input  1  per-word parity select (1 odd, 0 even); present only with UART_TX_PARITY_EN
- o_uart_tx  output  1  serial line, registered, idle high
- o_uart_busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty
- o_fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- The FIFO stores {parity_odd, data}. Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: o_uart_tx=1. If the FIFO is non-empty: pop the head into the shift register, clear the bit counter, and go to START.
- START: line 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: shift out the LSB first, DATA_BITS bits of CLKS_PER_BIT cycles each, then PARITY or STOP.
- PARITY: send XOR of the data bits, inverted when parity_odd=1, for CLKS_PER_BIT cycles.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end, if the FIFO is non-empty: pop and go directly to START, with no idle cycle.
  - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, is held at 0 in IDLE, and restarts on every state entry. Every bit is exactly CLKS_PER_BIT cycles.
- Push and pop in the same cycle: the level is unchanged and both take effect.
- A push is impossible when full, since ready is low; the data is ignored and the level stays FIFO_DEPTH.
- A pop only occurs from IDLE or at the end of STOP.

## Timing
- Reset values:
  - o_uart_tx=1
  - o_uart_busy=0
  - o_tx_ready=1
  - o_fifo_level=0
  - FSM=IDLE
  - FIFO pointers=0
- Reset asserted mid-frame: the line returns to 1 after the next edge, and FIFO contents are discarded.
- o_tx_ready = (level != FIFO_DEPTH), derived from the registered level.
- Latency: a word accepted at edge k with the FSM idle and the FIFO empty is popped at edge k+1. o_uart_tx falls after edge k+2 (registered output).
- o_uart_busy rises after edge k together with the level.
- Frame length in clocks = (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT, where P=1 with parity and 0 otherwise.
- o_uart_busy falls on the same edge the FSM enters IDLE with an empty FIFO.

## Configuration
- UART_TX_PARITY_EN defined:
  - i_parity_odd port exists.
  - The FIFO is DATA_BITS+1 wide.
  - The PARITY state is inserted after DATA.
- Undefined:
  - No port.
  - The FIFO is DATA_BITS wide.
  - DATA goes directly to STOP.
  - The frame has no parity bit.

## Test plan
Parameters for all scenarios: CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000 (10 clk/bit), DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
- Reset then idle: o_uart_tx=1, o_tx_ready=1, o_fifo_level=0, o_uart_busy=0 for 100 cycles.
- Send 0x5A without the macro: the line reads 0, then bits 0,1,0,1,1,0,1,0, then 1. Each bit lasts 10 cycles. The start bit falls 2 cycles after acceptance. o_uart_busy drops 100 cycles after the pop.
- Burst of 6 words 0x00..0x05 with i_tx_valid held high: ready falls when 4 are buffered and 1 is in flight. All 6 frames are contiguous, with no high gap longer than the 10-cycle stop bit.
- With the macro: 0x07 with odd=0 gives parity bit 1; 0x07 with odd=1 gives parity 0. The frame is 110 cycles.
- STOP_BITS=2, DATA_BITS=5, data 0x1F: the frame is 0, 1,1,1,1,1, 1,1, totalling 80 cycles.
- Assert i_rst mid-DATA with 2 words queued: after one edge o_uart_tx=1 and level=0. No further frames are sent.
